// File: rtl/mux_sel_rr_arbiter_if.sv
// Request/grant bundle between the requesting sources and the round-robin mux-select arbiter.
// The master side drives requests; the slave side (the arbiter) drives the mux controls.
interface mux_sel_rr_arbiter_if;
  logic [3:0] i_req;
  logic       i_release;
  logic [1:0] o_sel_code;
  logic       o_en;
  logic [3:0] o_grant;
  logic       o_timeout;

  modport master (
    output i_req,
    output i_release,
    input  o_sel_code,
    input  o_en,
    input  o_grant,
    input  o_timeout
  );

  modport slave (
    input  i_req,
    input  i_release,
    output o_sel_code,
    output o_en,
    output o_grant,
    output o_timeout
  );
endinterface

// File: rtl/mux_sel_rr_arbiter.sv
// Round-robin arbiter for four sources driving the select and enable of a 4:1 code mux.
// Each grant is bounded by a hold timer; one idle cycle always separates two grants.
module mux_sel_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input logic                 i_clk,
  input logic                 i_rst,
  mux_sel_rr_arbiter_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       grant_q, grant_d;
  logic             en_q, en_d;
  logic             timeout_q, timeout_d;

  // Round-robin pick: scan last+1, last+2, ... (mod 4), first requester wins.
  logic       pick_found;
  logic [1:0] pick_idx;
  logic [1:0] cand;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last_q;
    cand       = last_q;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!pick_found && bus.i_req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Grant end conditions; only meaningful while in StGrant.
  logic end_release;
  logic end_dropped;
  logic end_timer;
  logic grant_end;

  always_comb begin
    end_release = bus.i_release;
    end_dropped = !bus.i_req[sel_q];
    end_timer   = (cnt_q == CntMax);
    grant_end   = end_release || end_dropped || end_timer;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    sel_d     = sel_q;
    grant_d   = grant_q;
    en_d      = en_q;
    timeout_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        en_d    = 1'b0;
        grant_d = 4'b0000;
        cnt_d   = '0;
        if (pick_found) begin
          state_d = StGrant;
          sel_d   = pick_idx;
          grant_d = 4'b0001 << pick_idx;
          en_d    = 1'b1;
          last_d  = pick_idx;
        end
      end
      StGrant: begin
        if (grant_end) begin
          state_d   = StIdle;
          en_d      = 1'b0;
          grant_d   = 4'b0000;
          cnt_d     = '0;
          timeout_d = end_timer && !end_release && !end_dropped;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        en_d    = 1'b0;
        grant_d = 4'b0000;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      last_q    <= 2'd3;
      sel_q     <= 2'd0;
      grant_q   <= 4'b0000;
      en_q      <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      grant_q   <= grant_d;
      en_q      <= en_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.o_sel_code = sel_q;
  assign bus.o_en       = en_q;
  assign bus.o_grant    = grant_q;
  assign bus.o_timeout  = timeout_q;

`ifndef SYNTHESIS
  a_en_matches_grant: assert property (@(posedge i_clk) en_q == (|grant_q));
  a_grant_onehot_sel: assert property (@(posedge i_clk) !en_q || grant_q == (4'b0001 << sel_q));
`endif

endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// Self-checking bench for mux_sel_rr_arbiter: table-driven vectors through a scoreboard queue,
// plus hand-written round-robin and hold-timeout sequences.
module tb_mux_sel_rr_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_sel_rr_arbiter_if bus ();

  mux_sel_rr_arbiter #(
    .MAX_HOLD (8),
    .CNT_W    (4)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rel;
    logic       en;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       to;
  } vec_t;

  typedef struct {
    int         idx;
    logic       en;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       to;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req_val);
    checks++;
    if (act !== req_val) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req_val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic [3:0] q, input logic l, input logic e,
                     input logic [1:0] s, input logic [3:0] g, input logic t);
    vecs.push_back('{rst: r, req: q, rel: l, en: e, sel: s, grant: g, to: t});
  endtask

  task automatic wait_grant(input string name, output int waited);
    waited = 0;
    for (int n = 0; n < 12 && !bus.o_en; n++) begin
      tick();
      waited++;
    end
    chk({name, "_en"}, 8'(bus.o_en), 8'd1);
  endtask

  initial begin
    exp_t e;
    int   w;
    int   hi;
    int   early_to;

    rst = 1'b1;
    bus.i_req = 4'h0;
    bus.i_release = 1'b0;

    // reset: two cycles with all requests asserted
    add(1, 4'hF, 0, 0, 2'd0, 4'h0, 0);
    add(1, 4'hF, 0, 0, 2'd0, 4'h0, 0);
    // single request from source 2, released on its third grant cycle
    add(0, 4'h4, 0, 1, 2'd2, 4'h4, 0);
    add(0, 4'h4, 0, 1, 2'd2, 4'h4, 0);
    add(0, 4'h4, 0, 1, 2'd2, 4'h4, 0);
    add(0, 4'h4, 1, 0, 2'd2, 4'h0, 0);
    add(0, 4'h0, 0, 0, 2'd2, 4'h0, 0);
    // release coincides with the last hold cycle: no timeout pulse
    add(0, 4'h1, 0, 1, 2'd0, 4'h1, 0);
    for (int i = 0; i < 7; i++) add(0, 4'h1, 0, 1, 2'd0, 4'h1, 0);
    add(0, 4'h1, 1, 0, 2'd0, 4'h0, 0);
    // granted request dropped mid-grant
    add(0, 4'h1, 0, 1, 2'd0, 4'h1, 0);
    add(0, 4'h1, 0, 1, 2'd0, 4'h1, 0);
    add(0, 4'h0, 0, 0, 2'd0, 4'h0, 0);
    // release ignored in idle; a new request does not preempt
    add(0, 4'h2, 1, 1, 2'd1, 4'h2, 0);
    add(0, 4'h3, 0, 1, 2'd1, 4'h2, 0);
    add(0, 4'h1, 0, 0, 2'd1, 4'h0, 0);
    add(0, 4'h1, 0, 1, 2'd0, 4'h1, 0);
    add(0, 4'h0, 1, 0, 2'd0, 4'h0, 0);
    // reset while source 3 is granted, then 4'b1001 grants source 0
    add(0, 4'h8, 0, 1, 2'd3, 4'h8, 0);
    add(0, 4'h8, 0, 1, 2'd3, 4'h8, 0);
    add(1, 4'h8, 0, 0, 2'd0, 4'h0, 0);
    add(0, 4'h9, 0, 1, 2'd0, 4'h1, 0);
    add(0, 4'h0, 0, 0, 2'd0, 4'h0, 0);

    foreach (vecs[i]) begin
      rst           = vecs[i].rst;
      bus.i_req     = vecs[i].req;
      bus.i_release = vecs[i].rel;
      sb.push_back('{idx: i, en: vecs[i].en, sel: vecs[i].sel, grant: vecs[i].grant,
                     to: vecs[i].to});
      tick();
      e = sb.pop_front();
      chk($sformatf("vec%0d_en", e.idx), 8'(bus.o_en), 8'(e.en));
      chk($sformatf("vec%0d_sel", e.idx), 8'(bus.o_sel_code), 8'(e.sel));
      chk($sformatf("vec%0d_grant", e.idx), 8'(bus.o_grant), 8'(e.grant));
      chk($sformatf("vec%0d_timeout", e.idx), 8'(bus.o_timeout), 8'(e.to));
    end

    // round robin: all requesting, release on each grant's second cycle
    rst = 1'b1;
    bus.i_req = 4'hF;
    bus.i_release = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_grant($sformatf("rr%0d", k), w);
      chk($sformatf("rr%0d_idle_gap", k), 8'(w), 8'd1);
      chk($sformatf("rr%0d_sel", k), 8'(bus.o_sel_code), 8'(k % 4));
      tick();
      chk($sformatf("rr%0d_second_cycle", k), 8'(bus.o_en), 8'd1);
      bus.i_release = 1'b1;
      tick();
      bus.i_release = 1'b0;
      chk($sformatf("rr%0d_ended", k), 8'(bus.o_en), 8'd0);
    end

    // hold timeout: sole requester held with no release
    rst = 1'b1;
    bus.i_req = 4'h2;
    tick();
    rst = 1'b0;
    wait_grant("to", w);
    chk("to_latency", 8'(w), 8'd1);
    hi = 0;
    early_to = 0;
    for (int n = 0; n < 20 && bus.o_en; n++) begin
      if (bus.o_timeout) early_to++;
      hi++;
      tick();
    end
    chk("to_en_high_cycles", 8'(hi), 8'd8);
    chk("to_no_early_pulse", 8'(early_to), 8'd0);
    chk("to_pulse", 8'(bus.o_timeout), 8'd1);
    chk("to_en_low", 8'(bus.o_en), 8'd0);
    tick();
    chk("to_regrant_en", 8'(bus.o_en), 8'd1);
    chk("to_regrant_sel", 8'(bus.o_sel_code), 8'd1);
    chk("to_pulse_cleared", 8'(bus.o_timeout), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
